// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared types, winner codes and line table for the board judge
package board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_REPORT = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int          NUM_CELLS = 9;
    localparam logic [2:0]  LAST_LINE = 3'd7;

    // Cell indices of each line, scanned in this order: rows, columns, diagonals.
    localparam logic [3:0] LINE_CELLS [0:7][0:2] = '{
        '{4'd8, 4'd7, 4'd6},
        '{4'd5, 4'd4, 4'd3},
        '{4'd2, 4'd1, 4'd0},
        '{4'd8, 4'd5, 4'd2},
        '{4'd7, 4'd4, 4'd1},
        '{4'd6, 4'd3, 4'd0},
        '{4'd8, 4'd4, 4'd0},
        '{4'd6, 4'd4, 4'd2}
    };

    // A cell carrying both marks makes the board illegal.
    function automatic logic board_conflict(input logic [17:0] b);
        logic c;
        c = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            c = c | (b[2*k+1] & b[2*k]);
        end
        return c;
    endfunction

    // True when every cell carries at least one mark.
    function automatic logic board_full(input logic [17:0] b);
        logic f;
        f = 1'b1;
        for (int k = 0; k < NUM_CELLS; k++) begin
            f = f & (b[2*k+1] | b[2*k]);
        end
        return f;
    endfunction

endpackage

// File: rtl/line_eval.sv
// rtl/line_eval.sv - combinational ownership test of one three-cell line
module line_eval (
    input  logic [17:0] board_i,
    input  logic [3:0]  cell_a_i,
    input  logic [3:0]  cell_b_i,
    input  logic [3:0]  cell_c_i,
    output logic        p1_owns_o,
    output logic        p2_owns_o
);

    logic [8:0] p1_cells;
    logic [8:0] p2_cells;

    // Split the packed board into per-player occupancy vectors.
    always_comb begin
        p1_cells = '0;
        p2_cells = '0;
        for (int k = 0; k < 9; k++) begin
            p1_cells[k] = board_i[2*k+1];
            p2_cells[k] = board_i[2*k];
        end
    end

    assign p1_owns_o = p1_cells[cell_a_i] & p1_cells[cell_b_i] & p1_cells[cell_c_i];
    assign p2_owns_o = p2_cells[cell_a_i] & p2_cells[cell_b_i] & p2_cells[cell_c_i];

endmodule

// File: rtl/board_judge.sv
// rtl/board_judge.sv - judges each placed board for legality, win or draw
module board_judge
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [17:0] board,
    input  logic        clear,
    output logic [17:0] board_q,
    output logic        busy,
    output logic        done,
    output logic [1:0]  winner,
    output logic        draw,
    output logic [2:0]  win_line,
    output logic        illegal,
    output logic        turn,
    output logic        overrun
);

    state_e      state_q, state_d;
    logic [17:0] shadow_q, shadow_d;
    logic [2:0]  line_q, line_d;
    logic [17:0] board_d;
    logic        turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic        draw_q, draw_d;
    logic [2:0]  win_line_q, win_line_d;
    logic        illegal_q, illegal_d;
    logic        overrun_q, overrun_d;

    logic        p1_owns;
    logic        p2_owns;
    logic        conflict;
    logic        full;

    // Line 0 is evaluated already in CHECK, so line i resolves in cycle i+1.
    line_eval u_line_eval (
        .board_i   (shadow_q),
        .cell_a_i  (LINE_CELLS[line_q][0]),
        .cell_b_i  (LINE_CELLS[line_q][1]),
        .cell_c_i  (LINE_CELLS[line_q][2]),
        .p1_owns_o (p1_owns),
        .p2_owns_o (p2_owns)
    );

    assign conflict = board_conflict(shadow_q);
    assign full     = board_full(shadow_q);

    // State and result registers; reset abandons any evaluation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            line_q     <= '0;
            board_q    <= '0;
            turn_q     <= 1'b0;
            winner_q   <= WIN_NONE;
            draw_q     <= 1'b0;
            win_line_q <= '0;
            illegal_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            line_q     <= line_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            winner_q   <= winner_d;
            draw_q     <= draw_d;
            win_line_q <= win_line_d;
            illegal_q  <= illegal_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and result logic; clear overrides everything including load.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        line_d     = line_q;
        board_d    = board_q;
        turn_d     = turn_q;
        winner_d   = winner_q;
        draw_d     = draw_q;
        win_line_d = win_line_q;
        illegal_d  = illegal_q;
        overrun_d  = overrun_q;

        if (clear) begin
            state_d    = ST_IDLE;
            line_d     = '0;
            board_d    = '0;
            turn_d     = 1'b0;
            winner_d   = WIN_NONE;
            draw_d     = 1'b0;
            win_line_d = '0;
            illegal_d  = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        shadow_d   = board;
                        line_d     = '0;
                        winner_d   = WIN_NONE;
                        draw_d     = 1'b0;
                        win_line_d = '0;
                        illegal_d  = 1'b0;
                        state_d    = ST_CHECK;
                    end
                end
                ST_CHECK, ST_SCAN: begin
                    if (load) begin
                        overrun_d = 1'b1;
                    end
                    if ((state_q == ST_CHECK) && conflict) begin
                        illegal_d = 1'b1;
                        state_d   = ST_REPORT;
                    end else if (p1_owns || p2_owns) begin
                        winner_d   = p1_owns ? WIN_P1 : WIN_P2;
                        win_line_d = line_q;
                        state_d    = ST_REPORT;
                    end else if (line_q == LAST_LINE) begin
                        draw_d  = full;
                        state_d = ST_REPORT;
                    end else begin
                        line_d  = line_q + 3'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_REPORT: begin
                    if (load) begin
                        overrun_d = 1'b1;
                    end
                    if (!illegal_q) begin
                        board_d = shadow_q;
                        turn_d  = ~turn_q;
                    end
                    if ((winner_q != WIN_NONE) || draw_q) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == ST_CHECK) || (state_q == ST_SCAN) || (state_q == ST_REPORT);
    assign done     = (state_q == ST_REPORT);
    assign winner   = winner_q;
    assign draw     = draw_q;
    assign win_line = win_line_q;
    assign illegal  = illegal_q;
    assign turn     = turn_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_board_judge.sv
// tb/tb_board_judge.sv - scoreboard bench for board_judge
module tb_board_judge;
    import board_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [17:0] board = '0;
    logic        clear = 1'b0;
    logic [17:0] board_q;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        draw;
    logic [2:0]  win_line;
    logic        illegal;
    logic        turn;
    logic        overrun;

    always #5 clk = ~clk;

    board_judge dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .board    (board),
        .clear    (clear),
        .board_q  (board_q),
        .busy     (busy),
        .done     (done),
        .winner   (winner),
        .draw     (draw),
        .win_line (win_line),
        .illegal  (illegal),
        .turn     (turn),
        .overrun  (overrun)
    );

    typedef struct {
        int unsigned accept_cyc;
        int unsigned exp_cycle;
        logic [1:0]  winner;
        logic        draw;
        logic [2:0]  win_line;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          passed = 0;
    int          total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc - e.accept_cyc + 1, e.exp_cycle);
                    check("winner", 32'(winner), 32'(e.winner));
                    check("draw", 32'(draw), 32'(e.draw));
                    check("win_line", 32'(win_line), 32'(e.win_line));
                    check("illegal", 32'(illegal), 32'(e.illegal));
                end
            end
        end
    end

    // Called at a falling edge: load is sampled at the next rising edge (edge 0).
    task automatic issue_load(input logic [17:0] b, input logic [1:0] w, input logic d,
                              input logic [2:0] wl, input logic il, input int unsigned ec);
        exp_t e;
        e.accept_cyc = cyc + 1;
        e.exp_cycle  = ec;
        e.winner     = w;
        e.draw       = d;
        e.win_line   = wl;
        e.illegal    = il;
        exp_q.push_back(e);
        board = b;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({board_q, busy, done, winner, draw, win_line, illegal, turn, overrun}), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        // P1 top row: resolved in CHECK, game over.
        issue_load(18'h2A000, WIN_P1, 1'b0, 3'd0, 1'b0, 2);
        wait_done();
        check("win0_board_q", 32'(board_q), 32'h2A000);
        check("win0_turn", 32'(turn), 32'd1);
        check("win0_state", 32'(dut.state_q), 32'(ST_OVER));
        board = 18'h00001;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("over_load_busy", 32'(busy), 32'd0);
        check("over_load_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("over_stays", 32'(dut.state_q), 32'(ST_OVER));
        do_clear();
        check_all_zero("clear_after_win");
        check("clear_state", 32'(dut.state_q), 32'(ST_IDLE));

        // P2 anti-diagonal: last line.
        issue_load(18'h01110, WIN_P2, 1'b0, 3'd7, 1'b0, 9);
        wait_done();
        check("win7_board_q", 32'(board_q), 32'h01110);
        check("win7_state", 32'(dut.state_q), 32'(ST_OVER));
        do_clear();

        // Full board with no line: draw.
        issue_load(18'h2695A, WIN_NONE, 1'b1, 3'd0, 1'b0, 9);
        wait_done();
        check("draw_board_q", 32'(board_q), 32'h2695A);
        check("draw_turn", 32'(turn), 32'd1);
        check("draw_state", 32'(dut.state_q), 32'(ST_OVER));
        do_clear();

        // Legal open board, then an illegal one that must not disturb it.
        issue_load(18'h20000, WIN_NONE, 1'b0, 3'd0, 1'b0, 9);
        wait_done();
        check("open_board_q", 32'(board_q), 32'h20000);
        check("open_turn", 32'(turn), 32'd1);
        check("open_state", 32'(dut.state_q), 32'(ST_IDLE));
        issue_load(18'h00300, WIN_NONE, 1'b0, 3'd0, 1'b1, 2);
        wait_done();
        check("illegal_board_q", 32'(board_q), 32'h20000);
        check("illegal_turn", 32'(turn), 32'd1);
        check("illegal_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("illegal_held", 32'(illegal), 32'd1);

        // Second load in cycle 4 of a scan is ignored but flagged.
        issue_load(18'h00001, WIN_NONE, 1'b0, 3'd0, 1'b0, 9);
        repeat (3) @(negedge clk);
        board = 18'h2A000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_busy", 32'(busy), 32'd1);
        wait_done();
        check("overrun_board_q", 32'(board_q), 32'h00001);
        check("overrun_turn", 32'(turn), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        do_clear();
        check_all_zero("clear_after_overrun");
        check("clear_state2", 32'(dut.state_q), 32'(ST_IDLE));

        // Clear and load together: clear wins.
        board = 18'h2A000;
        load  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        clear = 1'b0;
        check("clear_load_busy", 32'(busy), 32'd0);
        check("clear_load_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (3) @(negedge clk);

        // Reset during a scan abandons it without a done pulse.
        board = 18'h20000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        repeat (3) @(negedge clk);
        check("scan_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("reset_scan_state", 32'(dut.state_q), 32'(ST_IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
